// File: rtl/udiv_pkg.sv
// Shared types and widths for the sequential unsigned restoring divider.
package udiv_pkg;

  localparam int unsigned DefaultN = 8;
  localparam int unsigned QW       = 2 * DefaultN;
  localparam int unsigned RW       = DefaultN + 1;

  localparam logic [QW-1:0] DBZ_QUOT = {QW{1'b1}};

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StDone
  } udiv_state_e;

endpackage

// File: rtl/udiv_restore_step.sv
// One combinational restoring-division iteration: shift in a dividend bit, trial-subtract.
module udiv_restore_step
  import udiv_pkg::*;
#(
  parameter int unsigned N = 8
) (
  input  logic [N:0]   prem,
  input  logic         dvd_bit,
  input  logic [N-1:0] divisor,
  output logic [N:0]   prem_next,
  output logic         q_bit
);

  logic [N+1:0] shifted;
  logic [N+1:0] diff;
  logic         unused_msbs;

  // The incoming remainder is always below the divisor, so the top shifted bit stays clear.
  assign shifted     = {prem, dvd_bit};
  assign diff        = shifted - {2'b00, divisor};
  assign q_bit       = (shifted >= {2'b00, divisor});
  assign prem_next   = q_bit ? diff[N:0] : shifted[N:0];
  assign unused_msbs = diff[N+1] ^ shifted[N+1];

endmodule

// File: rtl/udiv16by8_seq.sv
// Sequential unsigned restoring divider, 2N/N bits, valid/ready in and out.
// UDIV_APPROX_EN: skip the low APPROX_BITS quotient iterations (those bits forced to 0).
module udiv16by8_seq
  import udiv_pkg::*;
#(
  parameter int unsigned N           = 8,
  parameter int unsigned APPROX_BITS = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*N-1:0] dividend,
  input  logic [N-1:0]   divisor,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] quotient,
  output logic [N-1:0]   remainder,
  output logic           dbz
);

  localparam int unsigned QuotW = 2 * N;
  localparam int unsigned PremW = N + 1;
`ifdef UDIV_APPROX_EN
  localparam int unsigned Iter  = QuotW - APPROX_BITS;
  localparam int unsigned Skip  = APPROX_BITS;
`else
  localparam int unsigned Iter  = QuotW;
  localparam int unsigned Skip  = 0;
`endif
  localparam int unsigned CntW  = $clog2(QuotW + 1);

  if (APPROX_BITS >= QuotW) begin : g_bad_approx
    $error("APPROX_BITS must be below 2*N");
  end

  udiv_state_e state_q, state_d;

  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [QuotW-1:0] dvd_q, dvd_d;
  logic [N-1:0]     dvs_q, dvs_d;
  logic [PremW-1:0] prem_q, prem_d;
  logic [QuotW-1:0] quot_q, quot_d;
  logic [QuotW-1:0] quotient_q, quotient_d;
  logic [N-1:0]     remainder_q, remainder_d;
  logic             dbz_q, dbz_d;

  logic [PremW-1:0] step_prem;
  logic             step_qbit;
  logic [QuotW-1:0] quot_shift;

  udiv_restore_step #(
    .N(N)
  ) u_step (
    .prem     (prem_q),
    .dvd_bit  (dvd_q[QuotW-1]),
    .divisor  (dvs_q),
    .prem_next(step_prem),
    .q_bit    (step_qbit)
  );

  assign quot_shift = {quot_q[QuotW-2:0], step_qbit};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dvd_d       = dvd_q;
    dvs_d       = dvs_q;
    prem_d      = prem_q;
    quot_d      = quot_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    in_ready    = 1'b0;
    out_valid   = 1'b0;

    unique case (state_q)
      StIdle: begin
        in_ready = 1'b1;
        if (in_valid) begin
          dvd_d  = dividend;
          dvs_d  = divisor;
          prem_d = '0;
          quot_d = '0;
          cnt_d  = CntW'(Iter);
          if (divisor == '0) begin
            // Result is fixed by definition; skip the iterations entirely.
            quotient_d  = {QuotW{1'b1}};
            remainder_d = dividend[N-1:0];
            dbz_d       = 1'b1;
            state_d     = StDone;
          end else begin
            state_d = StCalc;
          end
        end
      end
      StCalc: begin
        dvd_d  = dvd_q << 1;
        prem_d = step_prem;
        quot_d = quot_shift;
        cnt_d  = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) begin
          quotient_d  = quot_shift << Skip;
          remainder_d = step_prem[N-1:0];
          state_d     = StDone;
        end
      end
      StDone: begin
        out_valid = 1'b1;
        if (out_ready) begin
          dbz_d   = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      dvd_q       <= '0;
      dvs_q       <= '0;
      prem_q      <= '0;
      quot_q      <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      dvd_q       <= dvd_d;
      dvs_q       <= dvs_d;
      prem_q      <= prem_d;
      quot_q      <= quot_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
    end
  end

  assign quotient  = quotient_q;
  assign remainder = remainder_q;
  assign dbz       = dbz_q;

endmodule
